// File: rtl/vape_region_protect.sv
// vape_region_protect
// Write guard for NUM_REG runtime-programmable protected address regions.
// CPU and DMA write traffic is checked against every enabled region. A hit
// kills the execution-integrity flag (exec) and is recorded in a sticky
// violation log: first offender address, source, region index, and a
// saturating count of violating cycles.
// The KILL -> RUN re-arm happens only when pc sits at the ER entry address
// in a cycle with no violation.
// Optional feature macro: VAPE_PROT_ER_EXIT_EN. When it is defined, leaving
// the executable region [ER_min, ER_max] also drops back to KILL.
module vape_region_protect #(
    parameter int ADDR_W  = 16,
    parameter int NUM_REG = 2,
    parameter int CNT_W   = 8,
    parameter int IDX_W   = 3
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [ADDR_W-1:0]         pc,
    input  logic [ADDR_W-1:0]         data_addr,
    input  logic                      data_en,
    input  logic [ADDR_W-1:0]         dma_addr,
    input  logic                      dma_en,
    input  logic [ADDR_W-1:0]         ER_min,
    input  logic [ADDR_W-1:0]         ER_max,
    input  logic [NUM_REG*ADDR_W-1:0] reg_min,
    input  logic [NUM_REG*ADDR_W-1:0] reg_max,
    input  logic [NUM_REG-1:0]        reg_en,
    input  logic                      viol_clr,
    output logic                      exec,
    output logic                      viol_valid,
    output logic [ADDR_W-1:0]         viol_addr,
    output logic                      viol_dma,
    output logic [IDX_W-1:0]          viol_idx,
    output logic [CNT_W-1:0]          viol_cnt
);

    typedef enum logic {
        KILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              state;

    logic [NUM_REG-1:0]  cpu_match;
    logic [NUM_REG-1:0]  dma_match;
    logic                cpu_hit;
    logic                dma_hit;
    logic                viol;
    logic [IDX_W-1:0]    cpu_idx;
    logic [IDX_W-1:0]    dma_idx;
    logic [ADDR_W-1:0]   lo;
    logic [ADDR_W-1:0]   hi;
    logic                at_entry;
    logic                in_er;

    // Per-region inclusive unsigned bound check for both write sources.
    // A region whose lower bound is above its upper bound can never satisfy
    // both compares, so it naturally matches nothing.
    always_comb begin
        cpu_match = '0;
        dma_match = '0;
        lo        = '0;
        hi        = '0;
        for (int i = 0; i < NUM_REG; i++) begin
            lo = reg_min[i*ADDR_W +: ADDR_W];
            hi = reg_max[i*ADDR_W +: ADDR_W];
            cpu_match[i] = reg_en[i] && (data_addr >= lo) && (data_addr <= hi);
            dma_match[i] = reg_en[i] && (dma_addr  >= lo) && (dma_addr  <= hi);
        end
    end

    // Priority encode the matches so the lowest region index wins.
    // Scanning downwards lets the lowest hit overwrite any higher one.
    always_comb begin
        cpu_idx = '0;
        dma_idx = '0;
        for (int i = NUM_REG - 1; i >= 0; i--) begin
            if (cpu_match[i]) begin
                cpu_idx = IDX_W'(i);
            end
            if (dma_match[i]) begin
                dma_idx = IDX_W'(i);
            end
        end
    end

    assign cpu_hit  = data_en && (|cpu_match);
    assign dma_hit  = dma_en  && (|dma_match);
    assign viol     = cpu_hit || dma_hit;
    assign at_entry = (pc == ER_min);

`ifdef VAPE_PROT_ER_EXIT_EN
    assign in_er = (pc >= ER_min) && (pc <= ER_max);
`else
    // Without the exit check, pc only matters at the entry address and
    // ER_max plays no part. It is folded into a signal that is never read.
    logic unused_er_max;
    assign unused_er_max = ^ER_max;
    assign in_er         = 1'b1;
`endif

    // Execution-integrity state machine. It re-arms only at ER entry on a
    // clean cycle and falls back to KILL on any violation (and, when the
    // feature is built in, on leaving ER).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= KILL;
        end else begin
            case (state)
                KILL: begin
                    if (at_entry && !viol) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (viol || !in_er) begin
                        state <= KILL;
                    end
                end
                default: state <= KILL;
            endcase
        end
    end

    // exec is combinational so that it drops in the same cycle as the
    // offending write, not one cycle later.
    assign exec = (state == RUN) && !viol && in_er;

    // Sticky violation log. A clear takes effect before a coinciding
    // violation, so that violation becomes the first logged event with a
    // count of one. CPU wins over DMA when both hit in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            viol_valid <= 1'b0;
            viol_addr  <= '0;
            viol_dma   <= 1'b0;
            viol_idx   <= '0;
            viol_cnt   <= '0;
        end else begin
            if (viol_clr) begin
                viol_valid <= 1'b0;
                viol_addr  <= '0;
                viol_dma   <= 1'b0;
                viol_idx   <= '0;
                viol_cnt   <= '0;
            end
            if (viol) begin
                if (viol_clr) begin
                    viol_cnt <= CNT_W'(1);
                end else if (viol_cnt != {CNT_W{1'b1}}) begin
                    viol_cnt <= viol_cnt + CNT_W'(1);
                end
                if (!viol_valid || viol_clr) begin
                    viol_valid <= 1'b1;
                    viol_dma   <= !cpu_hit;
                    viol_addr  <= cpu_hit ? data_addr : dma_addr;
                    viol_idx   <= cpu_hit ? cpu_idx : dma_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_vape_region_protect.sv
// tb_vape_region_protect
// Self-checking bench for vape_region_protect. A small behavioural model
// (region lookup, RUN flag and log record) predicts exec both before and
// after each clock edge, and the log contents after each edge.
// The bench follows VAPE_PROT_ER_EXIT_EN in the same way as the design.
module tb_vape_region_protect;

    localparam int ADDR_W  = 16;
    localparam int NUM_REG = 3;
    localparam int CNT_W   = 3;
    localparam int IDX_W   = 2;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                      clk;
    logic                      reset_n;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         data_addr;
    logic                      data_en;
    logic [ADDR_W-1:0]         dma_addr;
    logic                      dma_en;
    logic [ADDR_W-1:0]         ER_min;
    logic [ADDR_W-1:0]         ER_max;
    logic [NUM_REG*ADDR_W-1:0] reg_min;
    logic [NUM_REG*ADDR_W-1:0] reg_max;
    logic [NUM_REG-1:0]        reg_en;
    logic                      viol_clr;
    logic                      exec;
    logic                      viol_valid;
    logic [ADDR_W-1:0]         viol_addr;
    logic                      viol_dma;
    logic [IDX_W-1:0]          viol_idx;
    logic [CNT_W-1:0]          viol_cnt;

    int checks = 0;
    int errors = 0;

    // Model state.
    logic [ADDR_W-1:0] rMin [NUM_REG];
    logic [ADDR_W-1:0] rMax [NUM_REG];
    bit                rEn  [NUM_REG];
    bit                mRun;
    bit                mValid;
    logic [ADDR_W-1:0] mAddr;
    bit                mDma;
    int                mIdx;
    int                mCnt;

    vape_region_protect #(
        .ADDR_W (ADDR_W),
        .NUM_REG(NUM_REG),
        .CNT_W  (CNT_W),
        .IDX_W  (IDX_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .data_addr (data_addr),
        .data_en   (data_en),
        .dma_addr  (dma_addr),
        .dma_en    (dma_en),
        .ER_min    (ER_min),
        .ER_max    (ER_max),
        .reg_min   (reg_min),
        .reg_max   (reg_max),
        .reg_en    (reg_en),
        .viol_clr  (viol_clr),
        .exec      (exec),
        .viol_valid(viol_valid),
        .viol_addr (viol_addr),
        .viol_dma  (viol_dma),
        .viol_idx  (viol_idx),
        .viol_cnt  (viol_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return the first enabled region that contains addr, or -1.
    function automatic int hitIdx(input logic [ADDR_W-1:0] a);
        for (int i = 0; i < NUM_REG; i++) begin
            if (rEn[i] && a >= rMin[i] && a <= rMax[i]) return i;
        end
        return -1;
    endfunction

    // Report whether pc counts as inside ER for the configured build.
    function automatic bit inEr();
`ifdef VAPE_PROT_ER_EXIT_EN
        return (pc >= ER_min) && (pc <= ER_max);
`else
        return 1'b1;
`endif
    endfunction

    // Single comparison point: counts the check and reports any difference.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Program one region in both the model and the DUT inputs.
    task automatic setRegion(input int i, input logic [ADDR_W-1:0] lo,
                             input logic [ADDR_W-1:0] hi, input bit en);
        rMin[i] = lo;
        rMax[i] = hi;
        rEn[i]  = en;
        reg_min[i*ADDR_W +: ADDR_W] = lo;
        reg_max[i*ADDR_W +: ADDR_W] = hi;
        reg_en[i] = en;
    endtask

    // Clear the model to its reset values.
    task automatic resetModel();
        mRun   = 1'b0;
        mValid = 1'b0;
        mAddr  = '0;
        mDma   = 1'b0;
        mIdx   = 0;
        mCnt   = 0;
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input logic [ADDR_W-1:0] p,
                                 input logic [ADDR_W-1:0] da, input bit de,
                                 input logic [ADDR_W-1:0] ma, input bit me,
                                 input bit clr);
        pc        = p;
        data_addr = da;
        data_en   = de;
        dma_addr  = ma;
        dma_en    = me;
        viol_clr  = clr;
    endtask

    // Check exec before the edge, clock once, update the model, and check
    // exec and the log after the edge. Call this in the low clock phase.
    task automatic checkOutput(input string tag);
        int  cpuI;
        int  dmaI;
        bit  v;
        #1;
        cpuI = data_en ? hitIdx(data_addr) : -1;
        dmaI = dma_en  ? hitIdx(dma_addr)  : -1;
        v    = (cpuI >= 0) || (dmaI >= 0);
        chk({tag, ".exec_pre"}, exec, mRun && !v && inEr());
        @(posedge clk);
        if (viol_clr) begin
            mValid = 1'b0;
            mAddr  = '0;
            mDma   = 1'b0;
            mIdx   = 0;
            mCnt   = 0;
        end
        if (v) begin
            mCnt = (mCnt == CMAX) ? CMAX : mCnt + 1;
            if (!mValid) begin
                mValid = 1'b1;
                if (cpuI >= 0) begin
                    mAddr = data_addr;
                    mDma  = 1'b0;
                    mIdx  = cpuI;
                end else begin
                    mAddr = dma_addr;
                    mDma  = 1'b1;
                    mIdx  = dmaI;
                end
            end
        end
        if (!mRun) mRun = (pc == ER_min) && !v;
        else       mRun = !v && inEr();
        #1;
        chk({tag, ".exec_post"}, exec, mRun && !v && inEr());
        chk({tag, ".viol_valid"}, viol_valid, mValid);
        chk({tag, ".viol_addr"}, viol_addr, mAddr);
        chk({tag, ".viol_dma"}, viol_dma, mDma);
        chk({tag, ".viol_idx"}, viol_idx, mIdx[IDX_W-1:0]);
        chk({tag, ".viol_cnt"}, viol_cnt, mCnt[CNT_W-1:0]);
        @(negedge clk);
    endtask

    // Pick an address near an interesting region bound, or a random one.
    function automatic logic [ADDR_W-1:0] pickAddr();
        int r;
        int k;
        r = $urandom_range(0, NUM_REG - 1);
        k = $urandom_range(0, 5);
        case (k)
            0: return rMin[r];
            1: return rMax[r];
            2: return rMin[r] - 1'b1;
            3: return rMax[r] + 1'b1;
            4: return rMin[r] + ADDR_W'($urandom_range(0, 64));
            default: return ADDR_W'($urandom);
        endcase
    endfunction

    // Directed steps followed by a randomized phase.
    initial begin
        logic [ADDR_W-1:0] lo;
        reset_n = 1'b0;
        reg_min = '0;
        reg_max = '0;
        reg_en  = '0;
        ER_min  = 16'hE000;
        ER_max  = 16'hE0FF;
        applyStimulus(16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        setRegion(0, 16'hFFE0, 16'hFFFF, 1'b1);
        setRegion(1, 16'h0200, 16'h027F, 1'b1);
        setRegion(2, 16'h0200, 16'h0210, 1'b0);
        resetModel();
        repeat (2) @(negedge clk);

        chk("reset.exec", exec, 1'b0);
        chk("reset.viol_valid", viol_valid, 1'b0);
        chk("reset.viol_addr", viol_addr, 16'h0000);
        chk("reset.viol_dma", viol_dma, 1'b0);
        chk("reset.viol_idx", viol_idx, 2'd0);
        chk("reset.viol_cnt", viol_cnt, 3'd0);
        reset_n = 1'b1;

        // Re-arm at ER entry with no writes.
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("arm");
        applyStimulus(16'hE004, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("run_idle");

        // CPU write in region 1 while running.
        applyStimulus(16'hE008, 16'h0240, 1'b1, 16'h0000, 1'b0, 1'b0);
        checkOutput("cpu_r1");

        // Clear, then CPU and DMA hit together: CPU wins.
        applyStimulus(16'hE008, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("clear");
        applyStimulus(16'hE008, 16'hFFE0, 1'b1, 16'h0200, 1'b1, 1'b0);
        checkOutput("cpu_dma_same");

        // Violation at ER entry stays in KILL; a clean entry re-arms.
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'hFFF0, 1'b1, 1'b0);
        checkOutput("entry_viol");
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("entry_clean");

        // Overlapping regions: the lowest index wins. Clear coincides with DMA hit.
        setRegion(2, 16'h0200, 16'h0210, 1'b1);
        applyStimulus(16'hE010, 16'h0000, 1'b0, 16'h0205, 1'b1, 1'b1);
        checkOutput("clr_and_dma_overlap");

        // Saturate the counter.
        for (int i = 0; i < CMAX + 2; i++) begin
            applyStimulus(16'hE010, 16'h027F, 1'b1, 16'h0000, 1'b0, 1'b0);
            checkOutput("saturate");
        end

        // Clear and re-arm, then probe boundaries, an inverted region and disabled strobes.
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("clear2");
        setRegion(2, 16'h0300, 16'h0100, 1'b1);
        applyStimulus(16'hE004, 16'h0150, 1'b1, 16'h0150, 1'b1, 1'b0);
        checkOutput("inverted_region");
        applyStimulus(16'hE004, 16'h0280, 1'b1, 16'h01FF, 1'b1, 1'b0);
        checkOutput("just_outside");
        applyStimulus(16'hE004, 16'h0240, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        checkOutput("strobes_off");
        applyStimulus(16'hE004, 16'h0000, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        checkOutput("dma_upper_edge");

        // Leave ER while running (only kills with the exit feature built in).
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("rearm");
        applyStimulus(16'hE100, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("er_exit");

        // Asynchronous reset mid-RUN with a non-empty log.
        applyStimulus(16'hE000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("rearm2");
        applyStimulus(16'hE004, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        resetModel();
        chk("async_rst.exec", exec, 1'b0);
        chk("async_rst.viol_valid", viol_valid, 1'b0);
        chk("async_rst.viol_cnt", viol_cnt, 3'd0);
        chk("async_rst.viol_addr", viol_addr, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 0) begin
                for (int r = 0; r < NUM_REG; r++) begin
                    lo = ADDR_W'($urandom);
                    setRegion(r, lo, lo + ADDR_W'($urandom_range(0, 16'h0300)),
                              ($urandom_range(0, 3) != 0));
                end
            end
            applyStimulus(($urandom_range(0, 1) == 1) ? ER_min :
                          (($urandom_range(0, 1) == 1) ? ER_min + ADDR_W'($urandom_range(0, 300))
                                                       : ADDR_W'($urandom)),
                          pickAddr(), ($urandom_range(0, 3) == 0),
                          pickAddr(), ($urandom_range(0, 4) == 0),
                          ($urandom_range(0, 15) == 0));
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
